// File: rtl/pkt_cell_writer.sv
// pkt_cell_writer: ingress stage ahead of the cell allocator.
// Requests one cell per AXI-Stream packet, writes the packet beats into cell
// memory at {cell_id, beat_idx} and hands a {cell_id, len, err} descriptor to
// the scheduler. Packets with an illegal length, or for which no cell is
// granted, are swallowed whole and counted in drop_count.
//
// Handshake semantics (both stream ports): a transfer happens on a rising
// clk edge where valid & ready are both 1. A valid source holds its payload
// stable until that edge; ready may depend combinationally on state only,
// never on the partner's valid.
module pkt_cell_writer #(
  parameter int DATA_WIDTH      = 512,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int LEN_WIDTH       = 16,
  parameter int CELL_NUM        = 64,
  parameter int CELL_ID_WIDTH   = $clog2(CELL_NUM),
  parameter int CELL_BEATS      = 24,
  parameter int BEAT_IDX_WIDTH  = $clog2(CELL_BEATS),
  parameter bit DROP_ON_INTENSE = 1'b0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [DATA_WIDTH-1:0]                   s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]                   s_axis_tkeep,
  input  logic                                    s_axis_tvalid,
  output logic                                    s_axis_tready,
  input  logic                                    s_axis_tlast,
  input  logic [LEN_WIDTH-1:0]                    s_axis_tuser,
  output logic                                    alloc_mem_req,
  output logic [LEN_WIDTH-1:0]                    alloc_mem_size,
  input  logic [CELL_ID_WIDTH-1:0]                alloc_cell_id,
  input  logic                                    alloc_mem_success,
  input  logic                                    alloc_mem_intense,
  output logic                                    mem_wr_en,
  output logic [CELL_ID_WIDTH+BEAT_IDX_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0]                   mem_wr_data,
  output logic [KEEP_WIDTH-1:0]                   mem_wr_keep,
  output logic                                    m_desc_valid,
  input  logic                                    m_desc_ready,
  output logic [CELL_ID_WIDTH-1:0]                m_desc_cell_id,
  output logic [LEN_WIDTH-1:0]                    m_desc_len,
  output logic                                    m_desc_err,
  output logic [31:0]                             drop_count,
  output logic [1:0]                              state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam int unsigned MAX_LEN = CELL_BEATS * KEEP_WIDTH;
  localparam logic [BEAT_IDX_WIDTH-1:0] LAST_IDX = BEAT_IDX_WIDTH'(CELL_BEATS - 1);

  state_t                      state;
  logic [CELL_ID_WIDTH-1:0]    cell_id_q;
  logic [LEN_WIDTH-1:0]        len_q;
  logic [BEAT_IDX_WIDTH-1:0]   beat_idx;
  logic                        err_pend;

  logic accept;
  logic legal;
  logic grant;

  // Stream acceptance, length legality and allocation request for the first beat.
  always_comb begin
    s_axis_tready  = !rst && ((state == DROP) || !m_desc_valid);
    accept         = s_axis_tvalid && s_axis_tready;
    legal          = (s_axis_tuser != '0) &&
                     (32'(s_axis_tuser) <= MAX_LEN) &&
                     !(DROP_ON_INTENSE && alloc_mem_intense);
    alloc_mem_req  = (state == IDLE) && accept && legal;
    alloc_mem_size = s_axis_tuser;
    grant          = alloc_mem_req && alloc_mem_success;
  end

  // Memory write port: the first beat goes straight to the freshly granted cell.
  always_comb begin
    mem_wr_en   = grant || ((state == WRITE) && accept);
    mem_wr_addr = (state == IDLE) ? {alloc_cell_id, {BEAT_IDX_WIDTH{1'b0}}}
                                  : {cell_id_q, beat_idx};
    mem_wr_data = s_axis_tdata;
    mem_wr_keep = s_axis_tkeep;
    state_dbg   = state;
  end

  // Packet FSM, descriptor register and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cell_id_q      <= '0;
      len_q          <= '0;
      beat_idx       <= '0;
      err_pend       <= 1'b0;
      m_desc_valid   <= 1'b0;
      m_desc_cell_id <= '0;
      m_desc_len     <= '0;
      m_desc_err     <= 1'b0;
      drop_count     <= '0;
    end else begin
      if (m_desc_valid && m_desc_ready) begin
        m_desc_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            if (grant) begin
              cell_id_q <= alloc_cell_id;
              len_q     <= s_axis_tuser;
              beat_idx  <= BEAT_IDX_WIDTH'(1);
              if (s_axis_tlast) begin
                m_desc_valid   <= 1'b1;
                m_desc_cell_id <= alloc_cell_id;
                m_desc_len     <= s_axis_tuser;
                m_desc_err     <= 1'b0;
              end else begin
                state <= WRITE;
              end
            end else begin
              if (drop_count != 32'hFFFF_FFFF) begin
                drop_count <= drop_count + 32'd1;
              end
              if (!s_axis_tlast) begin
                state <= DROP;
              end
            end
          end
        end
        WRITE: begin
          if (accept) begin
            beat_idx <= beat_idx + 1'b1;
            if (s_axis_tlast) begin
              m_desc_valid   <= 1'b1;
              m_desc_cell_id <= cell_id_q;
              m_desc_len     <= len_q;
              m_desc_err     <= 1'b0;
              state          <= IDLE;
            end else if (beat_idx == LAST_IDX) begin
              // Cell is full: keep ownership, flag the truncation on the descriptor.
              err_pend <= 1'b1;
              state    <= DROP;
            end
          end
        end
        DROP: begin
          if (accept && s_axis_tlast) begin
            state <= IDLE;
            if (err_pend) begin
              m_desc_valid   <= 1'b1;
              m_desc_cell_id <= cell_id_q;
              m_desc_len     <= len_q;
              m_desc_err     <= 1'b1;
              err_pend       <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_cell_writer.sv
// Directed testbench for pkt_cell_writer.
module tb_pkt_cell_writer;

  localparam int DW  = 512;
  localparam int KW  = DW / 8;
  localparam int LW  = 16;
  localparam int CW  = 6;
  localparam int BW  = 5;

  logic          clk;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [LW-1:0] s_axis_tuser;
  logic          alloc_mem_req;
  logic [LW-1:0] alloc_mem_size;
  logic [CW-1:0] alloc_cell_id;
  logic          alloc_mem_success;
  logic          alloc_mem_intense;
  logic          mem_wr_en;
  logic [CW+BW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic [KW-1:0] mem_wr_keep;
  logic          m_desc_valid;
  logic          m_desc_ready;
  logic [CW-1:0] m_desc_cell_id;
  logic [LW-1:0] m_desc_len;
  logic          m_desc_err;
  logic [31:0]   drop_count;
  logic [1:0]    state_dbg;

  int pass_cnt = 0;
  int total    = 0;

  pkt_cell_writer dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tkeep      (s_axis_tkeep),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tuser      (s_axis_tuser),
    .alloc_mem_req     (alloc_mem_req),
    .alloc_mem_size    (alloc_mem_size),
    .alloc_cell_id     (alloc_cell_id),
    .alloc_mem_success (alloc_mem_success),
    .alloc_mem_intense (alloc_mem_intense),
    .mem_wr_en         (mem_wr_en),
    .mem_wr_addr       (mem_wr_addr),
    .mem_wr_data       (mem_wr_data),
    .mem_wr_keep       (mem_wr_keep),
    .m_desc_valid      (m_desc_valid),
    .m_desc_ready      (m_desc_ready),
    .m_desc_cell_id    (m_desc_cell_id),
    .m_desc_len        (m_desc_len),
    .m_desc_err        (m_desc_err),
    .drop_count        (drop_count),
    .state_dbg         (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one beat (called at posedge+1), check the combinational outputs at
  // the falling edge, then let the rising edge accept it.
  task automatic beat(input string tag, input logic last, input logic [LW-1:0] user,
                      input logic exp_wr, input logic [CW-1:0] id, input logic [BW-1:0] idx,
                      input logic exp_req);
    logic [DW-1:0] d;
    d = {16{$urandom()}};
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tuser  = user;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    chk({tag, ".tready"}, DW'(s_axis_tready), DW'(1'b1));
    chk({tag, ".req"},    DW'(alloc_mem_req), DW'(exp_req));
    chk({tag, ".wr_en"},  DW'(mem_wr_en),     DW'(exp_wr));
    if (exp_wr) begin
      chk({tag, ".addr"}, DW'(mem_wr_addr), DW'({id, idx}));
      chk({tag, ".data"}, mem_wr_data, d);
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic chk_desc(input string tag, input logic [CW-1:0] id, input logic [LW-1:0] len,
                          input logic err);
    chk({tag, ".dvalid"}, DW'(m_desc_valid),   DW'(1'b1));
    chk({tag, ".dcell"},  DW'(m_desc_cell_id), DW'(id));
    chk({tag, ".dlen"},   DW'(m_desc_len),     DW'(len));
    chk({tag, ".derr"},   DW'(m_desc_err),     DW'(err));
  endtask

  task automatic drain(input string tag);
    m_desc_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".hold_valid"}, DW'(m_desc_valid), DW'(1'b1));
    @(posedge clk); #1;
    m_desc_ready = 1'b0;
    chk({tag, ".drained"}, DW'(m_desc_valid), DW'(1'b0));
  endtask

  initial begin
    rst               = 1'b1;
    s_axis_tdata      = '0;
    s_axis_tkeep      = '1;
    s_axis_tvalid     = 1'b1;
    s_axis_tlast      = 1'b0;
    s_axis_tuser      = 16'd150;
    alloc_cell_id     = 6'd5;
    alloc_mem_success = 1'b1;
    alloc_mem_intense = 1'b0;
    m_desc_ready      = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.tready", DW'(s_axis_tready), DW'(1'b0));
    chk("rst.req",    DW'(alloc_mem_req), DW'(1'b0));
    chk("rst.wr_en",  DW'(mem_wr_en),     DW'(1'b0));
    chk("rst.dvalid", DW'(m_desc_valid),  DW'(1'b0));
    chk("rst.derr",   DW'(m_desc_err),    DW'(1'b0));
    chk("rst.drop",   DW'(drop_count),    DW'(32'd0));
    chk("rst.state",  DW'(state_dbg),     DW'(2'd0));
    s_axis_tvalid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: 3-beat packet into cell 5
    beat("p1.b0", 1'b0, 16'd150, 1'b1, 6'd5, 5'd0, 1'b1);
    chk("p1.keep", DW'(mem_wr_keep), DW'({KW{1'b1}}));
    chk("p1.state", DW'(state_dbg), DW'(2'd1));
    beat("p1.b1", 1'b0, 16'd150, 1'b1, 6'd5, 5'd1, 1'b0);
    beat("p1.b2", 1'b1, 16'd150, 1'b1, 6'd5, 5'd2, 1'b0);
    chk_desc("p1", 6'd5, 16'd150, 1'b0);
    chk("p1.state_end", DW'(state_dbg), DW'(2'd0));

    // 5: descriptor held 10 cycles, stream blocked
    alloc_cell_id = 6'd7;
    s_axis_tuser  = 16'd100;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp.tready", DW'(s_axis_tready), DW'(1'b0));
      chk("bp.wr_en",  DW'(mem_wr_en),     DW'(1'b0));
      chk("bp.req",    DW'(alloc_mem_req), DW'(1'b0));
      @(posedge clk); #1;
    end
    chk_desc("bp", 6'd5, 16'd150, 1'b0);
    drain("p1");
    beat("p2.b0", 1'b0, 16'd100, 1'b1, 6'd7, 5'd0, 1'b1);
    beat("p2.b1", 1'b1, 16'd100, 1'b1, 6'd7, 5'd1, 1'b0);
    chk_desc("p2", 6'd7, 16'd100, 1'b0);
    drain("p2");

    // 2: no grant -> drop whole packet
    alloc_mem_success = 1'b0;
    beat("nog.b0", 1'b0, 16'd128, 1'b0, 6'd7, 5'd0, 1'b1);
    chk("nog.state", DW'(state_dbg), DW'(2'd2));
    beat("nog.b1", 1'b1, 16'd128, 1'b0, 6'd7, 5'd0, 1'b0);
    chk("nog.dvalid", DW'(m_desc_valid), DW'(1'b0));
    chk("nog.drop",   DW'(drop_count),   DW'(32'd1));
    alloc_mem_success = 1'b1;

    // 3: illegal lengths never request a cell
    beat("len0.b0", 1'b1, 16'd0, 1'b0, 6'd7, 5'd0, 1'b0);
    chk("len0.drop", DW'(drop_count), DW'(32'd2));
    beat("len1537.b0", 1'b0, 16'd1537, 1'b0, 6'd7, 5'd0, 1'b0);
    beat("len1537.b1", 1'b1, 16'd1537, 1'b0, 6'd7, 5'd0, 1'b0);
    chk("len1537.drop",   DW'(drop_count),   DW'(32'd3));
    chk("len1537.dvalid", DW'(m_desc_valid), DW'(1'b0));

    // Boundary: 1536 bytes is still legal
    alloc_cell_id = 6'd3;
    beat("len1536.b0", 1'b1, 16'd1536, 1'b1, 6'd3, 5'd0, 1'b1);
    chk_desc("len1536", 6'd3, 16'd1536, 1'b0);
    drain("len1536");

    // 4: 26-beat packet overflows cell 9
    alloc_cell_id = 6'd9;
    for (int i = 0; i < 26; i++) begin
      beat("ovf", i == 25, 16'd1500, i < 24, 6'd9, 5'(i), i == 0);
      if (i == 23) chk("ovf.state_drop", DW'(state_dbg), DW'(2'd2));
    end
    chk_desc("ovf", 6'd9, 16'd1500, 1'b1);
    chk("ovf.drop", DW'(drop_count), DW'(32'd3));
    drain("ovf");

    // 6: reset on the 2nd beat of a 4-beat packet
    alloc_cell_id = 6'd4;
    beat("rp.b0", 1'b0, 16'd256, 1'b1, 6'd4, 5'd0, 1'b1);
    rst           = 1'b1;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    chk("rp.tready", DW'(s_axis_tready), DW'(1'b0));
    chk("rp.wr_en",  DW'(mem_wr_en),     DW'(1'b0));
    @(posedge clk); #1;
    rst           = 1'b0;
    s_axis_tvalid = 1'b0;
    chk("rp.dvalid", DW'(m_desc_valid), DW'(1'b0));
    chk("rp.state",  DW'(state_dbg),    DW'(2'd0));
    chk("rp.drop",   DW'(drop_count),   DW'(32'd0));
    alloc_cell_id = 6'd6;
    beat("rn.b0", 1'b0, 16'd128, 1'b1, 6'd6, 5'd0, 1'b1);
    beat("rn.b1", 1'b1, 16'd128, 1'b1, 6'd6, 5'd1, 1'b0);
    chk_desc("rn", 6'd6, 16'd128, 1'b0);
    drain("rn");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
